branch_predict_unit: RTL and testbench

Parametrised branch decision and prediction unit for the MIPS pipeline. It evaluates the branch condition from the ALU flags using an extended branch-type code and keeps a table of 2-bit saturating counters indexed by PC, which supplies a taken/not-taken prediction to fetch. Each resolved branch is checked against the prediction that was used for it. A one-cycle redirect pulse with the correct next PC goes back to fetch, and the counter table is trained. It sits between the execute stage (flags, branch code) and the PC-select logic.

---
 rtl/branch_predict_unit.sv | 121 ++++++++++++
 tb/tb_branch_predict_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch condition evaluation, 2-bit saturating-counter prediction table and
// registered redirect. Optional statistics counters enabled by BPU_STATS_EN.
module branch_predict_unit #(
  parameter int          ADDR_W    = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int          INDEX_LSB = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              pred_taken,
  input  logic              resolve_valid,
  input  logic [ADDR_W-1:0] resolve_pc,
  input  logic [2:0]        branch,
  input  logic              zero,
  input  logic              overflow,
  input  logic              negative,
  input  logic              resolve_pred,
  input  logic [ADDR_W-1:0] resolve_target,
  input  logic [ADDR_W-1:0] resolve_next,
  output logic              pcsrc,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       branch_count,
  output logic [31:0]       mispredict_count
);

  localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BGEZ = 3'b011,
    BR_BLEZ = 3'b100,
    BR_BGTZ = 3'b101,
    BR_BLTZ = 3'b110,
    BR_RSVD = 3'b111
  } br_e;

  br_e              code;
  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] resolve_idx;
  logic             taken;
  logic             is_event;
  logic             miss;
  logic             unused_pc_bits;

  assign code           = br_e'(branch);
  assign fetch_idx      = fetch_pc[INDEX_LSB +: IDX_W];
  assign resolve_idx    = resolve_pc[INDEX_LSB +: IDX_W];
  assign unused_pc_bits = ^{fetch_pc, resolve_pc};

  assign pred_taken = bht[fetch_idx][1];

  always_comb begin
    taken    = 1'b0;
    is_event = resolve_valid;
    case (code)
      BR_BEQ:  taken = zero & ~overflow;
      BR_BNE:  taken = ~zero;
      BR_BGEZ: taken = ~negative | zero;
      BR_BLEZ: taken = zero | negative;
      BR_BGTZ: taken = ~negative & ~zero;
      BR_BLTZ: taken = negative;
      default: is_event = 1'b0;
    endcase
  end

  assign miss = taken != resolve_pred;

  // Table write shares the edge with the output registers; lookups see no bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (is_event) begin
      if (taken && bht[resolve_idx] != 2'b11)
        bht[resolve_idx] <= bht[resolve_idx] + 2'd1;
      else if (!taken && bht[resolve_idx] != 2'b00)
        bht[resolve_idx] <= bht[resolve_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcsrc       <= 1'b0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else if (is_event) begin
      pcsrc       <= taken;
      mispredict  <= miss;
      redirect_pc <= taken ? resolve_target : resolve_next;
    end else begin
      pcsrc      <= 1'b0;
      mispredict <= 1'b0;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] mp_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (is_event) begin
      if (br_cnt != '1) br_cnt <= br_cnt + 32'd1;
      if (miss && mp_cnt != '1) mp_cnt <= mp_cnt + 32'd1;
    end
  end

  assign branch_count     = br_cnt;
  assign mispredict_count = mp_cnt;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with a behavioural reference model
// and a per-cycle compare process.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic [2:0]  branch;
  logic        zero, overflow, negative;
  logic        resolve_pred;
  logic [31:0] resolve_target, resolve_next;
  logic        pcsrc, mispredict;
  logic [31:0] redirect_pc, branch_count, mispredict_count;

  branch_predict_unit #(.ADDR_W(32), .BHT_DEPTH(64), .INDEX_LSB(2)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .branch(branch),
    .zero(zero), .overflow(overflow), .negative(negative),
    .resolve_pred(resolve_pred), .resolve_target(resolve_target),
    .resolve_next(resolve_next), .pcsrc(pcsrc), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          checking = 0;

  // Reference model: counter values 0..3 per table entry, expected outputs.
  int unsigned mctr [64];
  bit          exp_pcsrc, exp_mis, exp_pred;
  logic [31:0] exp_redirect;
  int unsigned exp_bc, exp_mc;

  function automatic int unsigned idx(input logic [31:0] pc);
    return (pc / 4) % 64;
  endfunction

  function automatic bit cond(input int code, input bit z, input bit o, input bit n);
    case (code)
      1: return z && !o;
      2: return !z;
      3: return !n || z;
      4: return z || n;
      5: return !n && !z;
      6: return n;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("pcsrc", {31'd0, pcsrc}, {31'd0, exp_pcsrc});
      chk("mispredict", {31'd0, mispredict}, {31'd0, exp_mis});
      chk("redirect_pc", redirect_pc, exp_redirect);
      chk("pred_taken", {31'd0, pred_taken}, {31'd0, exp_pred});
      chk("branch_count", branch_count, exp_bc);
      chk("mispredict_count", mispredict_count, exp_mc);
    end
  end

  // One cycle: drive, check pre-edge prediction, advance model after the edge.
  task automatic step(input bit rs, input bit v, input int code, input bit z,
                      input bit o, input bit n, input bit pred,
                      input logic [31:0] pc, input logic [31:0] tgt,
                      input logic [31:0] fpc);
    bit act;
    rst = rs; resolve_valid = v; branch = 3'(code);
    zero = z; overflow = o; negative = n; resolve_pred = pred;
    resolve_pc = pc; resolve_target = tgt; resolve_next = pc + 32'd4;
    fetch_pc = fpc;
    #1;
    if (checking) chk("pred_pre_edge", {31'd0, pred_taken}, {31'd0, mctr[idx(fpc)] >= 2});
    @(posedge clk);
    #1;
    if (rs) begin
      for (int i = 0; i < 64; i++) mctr[i] = 1;
      exp_pcsrc = 0; exp_mis = 0; exp_redirect = '0; exp_bc = 0; exp_mc = 0;
    end else if (v && code >= 1 && code <= 6) begin
      act = cond(code, z, o, n);
      exp_pcsrc = act;
      exp_mis = (act != pred);
      exp_redirect = act ? tgt : pc + 32'd4;
      if (act) mctr[idx(pc)] = (mctr[idx(pc)] == 3) ? 3 : mctr[idx(pc)] + 1;
      else     mctr[idx(pc)] = (mctr[idx(pc)] == 0) ? 0 : mctr[idx(pc)] - 1;
`ifdef BPU_STATS_EN
      exp_bc++;
      if (act != pred) exp_mc++;
`endif
    end else begin
      exp_pcsrc = 0; exp_mis = 0;
    end
    exp_pred = mctr[idx(fpc)] >= 2;
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input logic [31:0] fpc);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, fpc);
  endtask

  initial begin
    logic [31:0] bc_lit, mc_lit;
    @(negedge clk); #2;
    step(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checking = 1;
    step(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    chk("reset_redirect_lit", redirect_pc, 32'h0);

    // Every index predicts not-taken after reset.
    for (int i = 0; i < 64; i++) idle(32'(i * 4));

    // BEQ taken, predicted not-taken; lookup of same index has no bypass.
    step(0, 1, 1, 1, 0, 0, 0, 32'h40, 32'h100, 32'h40);
    chk("beq_pcsrc_lit", {31'd0, pcsrc}, 32'd1);
    chk("beq_mis_lit", {31'd0, mispredict}, 32'd1);
    chk("beq_redirect_lit", redirect_pc, 32'h100);
    chk("beq_ctr_lit", mctr[16], 32'd2);
    chk("beq_pred_lit", {31'd0, pred_taken}, 32'd1);

    // Three more taken back-to-back, then one not-taken.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 0, 1, 32'h40, 32'h100, 32'h40);
    chk("sat_ctr_lit", mctr[16], 32'd3);
    step(0, 1, 1, 0, 0, 0, 1, 32'h40, 32'h100, 32'h40);
    chk("nt_redirect_lit", redirect_pc, 32'h44);
    chk("nt_ctr_lit", mctr[16], 32'd2);
    chk("nt_pred_lit", {31'd0, pred_taken}, 32'd1);
    idle(32'h140);  // aliases index 16

    // Non-event codes with valid asserted.
    step(0, 1, 7, 1, 0, 1, 0, 32'h80, 32'h200, 32'h80);
    chk("rsvd_pcsrc_lit", {31'd0, pcsrc}, 32'd0);
    step(0, 1, 0, 1, 0, 1, 1, 32'h80, 32'h200, 32'h80);
    chk("none_mis_lit", {31'd0, mispredict}, 32'd0);
    chk("none_redirect_hold_lit", redirect_pc, 32'h44);

    // Hand-computed condition pins.
    step(0, 1, 5, 1, 0, 0, 1, 32'h400, 32'h800, 32'h400);
    chk("bgtz_zero_lit", {31'd0, pcsrc}, 32'd0);
    step(0, 1, 6, 0, 0, 1, 0, 32'h404, 32'h900, 32'h404);
    chk("bltz_neg_lit", {31'd0, pcsrc}, 32'd1);
    chk("bltz_redirect_lit", redirect_pc, 32'h900);

    // Full code x flag sweep.
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 8; f++)
        step(0, 1, c, f[0], f[1], f[2], 1'($urandom_range(0, 1)),
             32'h1000 + 32'((c * 8 + f) * 4), 32'h2000 + 32'(c * 16 + f),
             32'h1000 + 32'(f * 4));
    idle(32'h0);

    // Statistics: 5 events, 2 mispredicts at index 0.
    step(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h300);
    step(0, 1, 2, 0, 0, 0, 1, 32'h300, 32'h3000, 32'h300);
    step(0, 1, 2, 1, 0, 0, 0, 32'h300, 32'h3000, 32'h300);
    step(0, 1, 6, 0, 0, 1, 0, 32'h300, 32'h3000, 32'h300);
    step(0, 1, 3, 0, 0, 1, 1, 32'h300, 32'h3000, 32'h300);
    step(0, 1, 4, 1, 0, 0, 1, 32'h300, 32'h3000, 32'h300);
`ifdef BPU_STATS_EN
    bc_lit = 32'd5; mc_lit = 32'd2;
`else
    bc_lit = 32'd0; mc_lit = 32'd0;
`endif
    chk("stats_branch_lit", branch_count, bc_lit);
    chk("stats_mis_lit", mispredict_count, mc_lit);

    // Reset coincident with a mispredicting event discards it.
    step(1, 1, 2, 0, 0, 0, 0, 32'h300, 32'h3000, 32'h300);
    chk("rst_evt_mis_lit", {31'd0, mispredict}, 32'd0);
    chk("rst_evt_bc_lit", branch_count, 32'd0);
    chk("rst_evt_mc_lit", mispredict_count, 32'd0);
    idle(32'h300);

    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
